// File: rtl/uart_rx_pkg.sv
// Shared UART constants: baud divisors at a 12 MHz system clock plus the
// half-period helper used to centre sampling on the start bit.
package uart_rx_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;

    function automatic int half_period(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_baudgen_rx.sv
// Mod-N tick counter for the receiver: N is DIV, or DIV/2 when half_i is set.
// restart_i holds the count at zero so every period starts from a clean edge.
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV = B115200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int HALF = half_period(DIV);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;

    assign last   = half_i ? HALF_LAST : FULL_LAST;
    assign tick_o = !restart_i && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle
// rcv / frame_err strobes, and a BREAK state that waits out a held-low line.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV = B115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              rcv,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_e;

    state_e            state_q;
    logic              sync1_q, rx_s_q;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] data_q;
    logic              rcv_q, frame_err_q, busy_q;
    logic              tick;
    logic              restart;
    logic              half_sel;

    // Divider sits at zero while idle or in break, so entering START always
    // begins a fresh half period; later transitions coincide with a wrap.
    assign restart  = (state_q == ST_IDLE) || (state_q == ST_BRK);
    assign half_sel = (state_q == ST_START);

    baudgen_rx #(
        .DIV(DIV)
    ) u_baudgen (
        .clk_i    (clk),
        .rst_i    (rst),
        .restart_i(restart),
        .half_i   (half_sel),
        .tick_o   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= 3'd0;
            data_q      <= '0;
            rcv_q       <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rcv_q       <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg_q   <= {rx_s_q, shreg_q[DATA_W-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            data_q  <= shreg_q;
                            rcv_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign rcv       = rcv_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
